// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, nibble constants and BCD validity check for the BCD-to-binary converter
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] NIB_ADJ_MIN = 4'd8;  // nibbles at or above this get corrected
  localparam logic [3:0] NIB_ADJ_SUB = 4'd3;  // correction amount after a right shift
  localparam logic [3:0] NIB_MAX     = 4'd9;  // largest legal BCD digit

  // True when every one of the low `digits` nibbles of `word` is a legal BCD digit.
  // The word is passed zero-extended to 32 bits so one function serves any DIGITS up to 8.
  function automatic logic bcd_is_valid(input logic [31:0] word, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((i < digits) && (word[4*i +: 4] > NIB_MAX)) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// rtl/bcd_to_binary_seq_if.sv - start/result handshake bundle between requester and converter
// Ports (signals):
//   start  : request a conversion
//   bcd    : packed BCD operand, most significant digit in the top nibble
//   binary : converted result, held until the next done
//   busy   : converter is iterating
//   done   : one-cycle result-valid pulse
//   error  : captured operand had a digit above 9
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic [BIN_W-1:0]      binary;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (output start, bcd, input binary, busy, done, error);
  modport slave  (input start, bcd, output binary, busy, done, error);
endinterface

// File: rtl/bcd_nibble_adjust.sv
// rtl/bcd_nibble_adjust.sv - subtract 3 from a BCD nibble that reads 8 or more after a right shift
// Ports:
//   i_nibble : nibble taken from the freshly shifted scratch word
//   o_nibble : corrected nibble
module bcd_nibble_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  // A bit shifted down from the next-higher digit lands here as weight 8 but is worth 5.
  assign o_nibble = (i_nibble >= NIB_ADJ_MIN) ? (i_nibble - NIB_ADJ_SUB) : i_nibble;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential reverse double-dabble BCD-to-binary converter with start/busy/done handshake
// Ports:
//   i_clock   : system clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   io        : slave side of bcd_to_binary_seq_if (start, bcd in; binary, busy, done, error out)
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  bcd_to_binary_seq_if.slave    io
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // The largest BCD value must fit in the binary result.
  generate
    if ((2 ** BIN_W) < (10 ** DIGITS)) begin : g_bad_width
      $error("bcd_to_binary_seq: BIN_W too small for DIGITS");
    end
  endgenerate

  state_t             r_state;
  logic [SCR_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_count;
  logic [BIN_W-1:0]   r_binary;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic [SCR_W-1:0]   w_shifted;
  logic [SCR_W-1:0]   w_adjusted;
  logic               w_valid;

  assign w_valid   = bcd_is_valid(32'(io.bcd), DIGITS);
  assign w_shifted = r_scratch >> 1;

  // Binary field passes straight through; only the BCD digits need correcting.
  assign w_adjusted[BIN_W-1:0] = w_shifted[BIN_W-1:0];

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_nibble_adjust u_adj (
        .i_nibble (w_shifted[BIN_W + 4*g +: 4]),
        .o_nibble (w_adjusted[BIN_W + 4*g +: 4])
      );
    end
  endgenerate

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_scratch <= '0;
      r_count   <= '0;
      r_binary  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (io.start) begin
            if (w_valid) begin
              r_scratch <= {io.bcd, {BIN_W{1'b0}}};
              r_count   <= '0;
              r_busy    <= 1'b1;
              r_state   <= SHIFT;
            end else begin
              // Illegal digit: report immediately without iterating.
              r_binary <= '0;
              r_error  <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end else begin
            r_state <= IDLE;
          end
        end

        SHIFT: begin
          // The counter is compared before shifting, so the cycle after the last
          // iteration is spent publishing the result rather than shifting again.
          if (r_count == CNT_W'(BIN_W)) begin
            assert (r_scratch[SCR_W-1:BIN_W] == '0);
            r_binary <= r_scratch[BIN_W-1:0];
            r_error  <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_scratch <= w_adjusted;
            r_count   <= r_count + CNT_W'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign io.binary = r_binary;
  assign io.busy   = r_busy;
  assign io.done   = r_done;
  assign io.error  = r_error;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - self-checking bench for bcd_to_binary_seq (default and 3-digit builds)
module tb_bcd_to_binary_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_to_binary_seq_if #(.DIGITS(2), .BIN_W(7))  ifa ();
  bcd_to_binary_seq_if #(.DIGITS(3), .BIN_W(10)) ifb ();

  bcd_to_binary_seq #(.DIGITS(2), .BIN_W(7)) dut_a (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io        (ifa.slave)
  );

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut_b (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io        (ifb.slave)
  );

  typedef struct {
    logic [31:0] bin;
    logic        err;
    int          edge_idx;
    int          busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_bin(input int w);
    return (w == 0) ? 32'(ifa.binary) : 32'(ifb.binary);
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 0) ? ifa.busy : ifb.busy;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 0) ? ifa.done : ifb.done;
  endfunction
  function automatic logic get_err(input int w);
    return (w == 0) ? ifa.error : ifb.error;
  endfunction

  task automatic set_in(input int w, input logic s, input logic [31:0] b);
    if (w == 0) begin
      ifa.start = s;
      ifa.bcd   = b[7:0];
    end else begin
      ifb.start = s;
      ifb.bcd   = b[11:0];
    end
  endtask

  // One Start pulse; expectation is queued, then popped when done appears.
  task automatic convert(input int w, input logic [31:0] bcd, input logic [31:0] exp_bin,
                         input logic exp_err, input string tag);
    exp_t e;
    exp_t p;
    int   edge_i;
    int   busy_n;
    bit   got;
    int   bw;
    bw            = (w == 0) ? 7 : 10;
    e.bin         = exp_bin;
    e.err         = exp_err;
    e.edge_idx    = exp_err ? 0 : bw + 1;
    e.busy_cycles = exp_err ? 0 : bw + 1;
    sb.push_back(e);
    @(negedge clk);
    set_in(w, 1'b1, bcd);
    @(posedge clk);
    edge_i = 0;
    busy_n = 0;
    got    = 1'b0;
    @(negedge clk);
    set_in(w, 1'b0, bcd);
    for (int k = 0; k < 30 && !got; k++) begin
      if (get_busy(w) && get_done(w)) chk({tag, "_busy_done_overlap"}, 32'd1, 32'd0);
      if (get_busy(w)) busy_n++;
      if (get_done(w)) begin
        got = 1'b1;
        p   = sb.pop_front();
        chk({tag, "_binary"}, get_bin(w), p.bin);
        chk({tag, "_error"}, 32'(get_err(w)), 32'(p.err));
        chk({tag, "_done_edge"}, 32'(edge_i), 32'(p.edge_idx));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(p.busy_cycles));
      end else begin
        @(posedge clk);
        edge_i++;
        @(negedge clk);
      end
    end
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(get_done(w)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ndone;
    int          last;
    logic [31:0] bcd;

    rst_n = 1'b0;
    set_in(0, 1'b0, 32'h0);
    set_in(1, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_a_binary", get_bin(0), 32'd0);
    chk("rst_a_busy", 32'(get_busy(0)), 32'd0);
    chk("rst_a_done", 32'(get_done(0)), 32'd0);
    chk("rst_a_error", 32'(get_err(0)), 32'd0);
    chk("rst_b_binary", get_bin(1), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_a_busy", 32'(get_busy(0)), 32'd0);
    chk("idle_a_done", 32'(get_done(0)), 32'd0);

    // Directed values.
    convert(0, 32'h45, 32'd45, 1'b0, "bcd45");
    convert(0, 32'h99, 32'd99, 1'b0, "bcd99");
    convert(0, 32'h00, 32'd0,  1'b0, "bcd00");
    convert(0, 32'h10, 32'd10, 1'b0, "bcd10");

    // Invalid digits; binary was 10 before, so a cleared result is visible.
    convert(0, 32'hA5, 32'd0, 1'b1, "bcdA5");
    convert(0, 32'h3F, 32'd0, 1'b1, "bcd3F");
    convert(0, 32'h45, 32'd45, 1'b0, "bcd45_after_err");

    // Full sweep of legal two-digit inputs against decimal value.
    for (int i = 0; i < 100; i++) begin
      bcd = ((i / 10) << 4) | (i % 10);
      convert(0, bcd, 32'(i), 1'b0, "sweep");
    end

    // Start pulses with a new operand while busy must be ignored.
    @(negedge clk);
    set_in(0, 1'b1, 32'h37);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 32'h37);
    @(negedge clk);
    @(negedge clk);
    set_in(0, 1'b1, 32'h12);
    @(negedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 32'h12);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (get_done(0)) begin
        ndone++;
        chk("ignore_start_binary", get_bin(0), 32'd37);
      end
    end
    chk("ignore_start_done_count", 32'(ndone), 32'd1);

    // Asynchronous reset during iteration 4 of 0x58.
    @(negedge clk);
    set_in(0, 1'b1, 32'h58);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 32'h58);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_binary", get_bin(0), 32'd0);
    chk("midrst_busy", 32'(get_busy(0)), 32'd0);
    chk("midrst_done", 32'(get_done(0)), 32'd0);
    chk("midrst_error", 32'(get_err(0)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (get_done(0)) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    convert(0, 32'h23, 32'd23, 1'b0, "after_rst_23");

    // Start held high: a done every 9 cycles.
    @(negedge clk);
    set_in(0, 1'b1, 32'h59);
    ndone = 0;
    last  = -1;
    for (int e = 0; e < 36; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_busy(0) && get_done(0)) chk("b2b_busy_done_overlap", 32'd1, 32'd0);
      if (get_done(0)) begin
        chk("b2b_binary", get_bin(0), 32'd59);
        if (last >= 0) chk("b2b_period", 32'(e - last), 32'd9);
        else chk("b2b_first_edge", 32'(e), 32'd8);
        last = e;
        ndone++;
      end
    end
    set_in(0, 1'b0, 32'h59);
    chk("b2b_done_count", 32'(ndone), 32'd4);
    repeat (12) @(negedge clk);

    // Three-digit build.
    convert(1, 32'h999, 32'd999, 1'b0, "b_999");
    convert(1, 32'h000, 32'd0,   1'b0, "b_000");
    convert(1, 32'h512, 32'd512, 1'b0, "b_512");
    convert(1, 32'h5A0, 32'd0,   1'b1, "b_5A0");
    convert(1, 32'h407, 32'd407, 1'b0, "b_407");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
